acc_drain_serializer: RTL and testbench
=======================================

Name: acc_drain_serializer

Overview:
Readout end of the systolic PE array's accumulator interface. Snapshots the final accumulator values of N PE columns on a capture pulse and issues the matching accumulator-clear (load_acc) pulse so the PEs can start the next tile. It then requantizes each value by a programmable rounding right-shift and streams the results out one per handshake on a valid/ready interface. Sits between the PE array and the output feature-map writer.

Parameters:
N, 4, number of PE accumulators drained per capture (N >= 2)
ACCW, 32, accumulator width (matches PE accumulator)
OW, 8, output sample width
SHIFTW, 5, width of shift-amount input

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
acc_in  input  N*ACCW  flattened signed accumulators; column 0 at bits [ACCW-1:0]
capture  input  1  single-cycle pulse: acc_in holds final tile results
shift  input  SHIFTW  arithmetic right-shift amount; sampled with capture
clr_acc  output  1  one-cycle pulse; drives PE load_acc
busy  output  1  high while a captured set is still draining
overrun  output  1  sticky: capture arrived while busy
out_data  output  OW  signed requantized sample
out_idx  output  clog2(N)  column index of out_data
out_valid  output  1  out_data/out_idx valid
out_ready  input  1  downstream accept
out_last  output  1  high with out_valid on column N-1

Behaviour:
- Reset values: clr_acc=0, busy=0, overrun=0, out_valid=0, out_last=0, out_idx=0, out_data=0, capture buffer cleared, shift register 0. FSM in IDLE.
- FSM states IDLE and DRAIN. busy = (state==DRAIN).
- IDLE + capture at edge k: latch all N acc_in words and shift into internal registers. Drive clr_acc=1 for the cycle after edge k only. Go to DRAIN with idx=0. out_valid is high from edge k onward, with column 0 data visible in cycle k+1.
- DRAIN: out_valid=1, out_idx=idx, out_data=quant(buf[idx]), out_last=(idx==N-1). Transfer occurs when out_valid && out_ready at a clock edge.
- On transfer with idx<N-1: idx increments.
- On transfer with idx==N-1: return to IDLE; out_valid, out_last and out_idx go to 0 on that edge.
- Without a transfer, out_data, out_idx and out_last are held stable.
- capture while in DRAIN: ignored. Buffer is unchanged, no clr_acc is issued, overrun is set to 1. overrun clears only on reset.
- capture on the same edge as the final transfer: treated as busy, so it is ignored and sets overrun. The next capture is accepted only in IDLE.
- out_data is 0 whenever out_valid=0.
- quant(x): computed in ACCW+1 bits to avoid overflow.
  - If shift==0: r = x.
  - Otherwise: r = (x + 2^(shift-1)) >>> shift (round half up, arithmetic shift).
  - Without the optional feature, out_data = r[OW-1:0] (two's-complement wrap).
  - shift >= ACCW yields r = 0 for x >= 0 and r = -1 for x < 0, before rounding carry.
- clr_acc timing: integration guarantees PE ce is high during the clr_acc cycle. The block takes no ce input.
- Reset asserted mid-DRAIN: the drain aborts immediately, all outputs return to reset values, and the buffered data is discarded.

Optional Feature:
- Macro ACC_DRAIN_SAT_EN.
- Defined: r is saturated to [-2^(OW-1), 2^(OW-1)-1] before output.
- Undefined: r is truncated to its OW LSBs (wrap).
- Rounding, handshake and timing are identical in both builds.

Test Plan:
- Basic drain. N=4, OW=8, shift=2, acc_in = {col0=100, col1=-3, col2=1000, col3=-1000}, out_ready=1, capture pulse. Required: clr_acc high exactly one cycle. Four consecutive beats with out_idx 0..3 and out_data 0x19, 0xFF, then 0xFA/0x06 (wrap) or 0x7F/0x80 (ACC_DRAIN_SAT_EN). out_last only on idx 3. busy drops after beat 3.
- Backpressure. Same data with out_ready toggling 1,0,0,1,0,1,1. Required: exactly 4 transfers, out_data/out_idx stable while stalled, no duplicated or skipped columns.
- Overrun. Second capture 1 cycle after the first (during DRAIN) with different acc_in. Required: original values drained unchanged, overrun=1 and stays 1, clr_acc pulses only once.
- Shift=0 and extreme values. acc col0 = 0x7FFFFFFF, col1 = 0x80000000, col2 = 5, col3 = -5. Required: wrap build gives 0xFF, 0x00, 0x05, 0xFB. SAT build gives 0x7F, 0x80, 0x05, 0xFB.
- Rounding ties. shift=1, acc = {3, -3, 1, -1}. Required: 2, -1, 1, 0 (0x02, 0xFF, 0x01, 0x00).
- Reset mid-drain. Assert rst_n low after beat 1. Required: all outputs 0 asynchronously. After release the block is idle, and a new capture drains correctly starting from idx 0.

Source files
------------

// File: rtl/acc_drain_serializer.sv
// Accumulator drain: snapshots N PE accumulators on capture, pulses clr_acc, streams requantized samples.
// Optional saturation of the requantized result: define ACC_DRAIN_SAT_EN (default build wraps).

module acc_drain_quant #(
    parameter int ACCW   = 32,
    parameter int OW     = 8,
    parameter int SHIFTW = 5
) (
    input  logic [ACCW-1:0]   acc,
    input  logic [SHIFTW-1:0] shift,
    output logic [OW-1:0]     q
);
    localparam logic signed [ACCW:0] ONE = (ACCW+1)'(1);

    logic signed [ACCW:0] xe, rnd, r;

    // One extra bit of headroom so the rounding add cannot overflow.
    always_comb begin
        xe  = {acc[ACCW-1], acc};
        rnd = '0;
        r   = xe;
        if (shift != '0) begin
            rnd = ONE << (shift - SHIFTW'(1));
            r   = (xe + rnd) >>> shift;
        end
        if (int'(shift) >= ACCW)
            r = {(ACCW+1){xe[ACCW]}};
    end

`ifdef ACC_DRAIN_SAT_EN
    localparam logic signed [ACCW:0] QMAX = {{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW:0] QMIN = {{(ACCW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        if (r > QMAX)      q = QMAX[OW-1:0];
        else if (r < QMIN) q = QMIN[OW-1:0];
        else               q = r[OW-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^r[ACCW:OW];
    assign q = r[OW-1:0];
`endif
endmodule

module acc_drain_serializer #(
    parameter int N      = 4,
    parameter int ACCW   = 32,
    parameter int OW     = 8,
    parameter int SHIFTW = 5,
    parameter int IW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*ACCW-1:0] acc_in,
    input  logic              capture,
    input  logic [SHIFTW-1:0] shift,
    output logic              clr_acc,
    output logic              busy,
    output logic              overrun,
    output logic [OW-1:0]     out_data,
    output logic [IW-1:0]     out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                      state;
    logic [N-1:0][ACCW-1:0]      acc_buf;
    logic [SHIFTW-1:0]           shift_q;
    logic [N-1:0][OW-1:0]        lane_q;

    for (genvar g = 0; g < N; g++) begin : g_lane
        acc_drain_quant #(.ACCW(ACCW), .OW(OW), .SHIFTW(SHIFTW)) u_quant (
            .acc   (acc_buf[g]),
            .shift (shift_q),
            .q     (lane_q[g])
        );
    end

    assign busy     = (state == DRAIN);
    assign out_data = out_valid ? lane_q[out_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_buf   <= '0;
            shift_q   <= '0;
            clr_acc   <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            clr_acc <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        acc_buf   <= acc_in;
                        shift_q   <= shift;
                        clr_acc   <= 1'b1;
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Capture while draining (including the final beat's edge) is dropped.
                    if (capture)
                        overrun <= 1'b1;
                    if (out_ready) begin
                        if (out_idx == IW'(N-1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_last <= (out_idx == IW'(N-2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_drain_serializer.sv
// Directed bench for acc_drain_serializer (N=4, ACCW=32, OW=8); expectations follow ACC_DRAIN_SAT_EN.

module tb_acc_drain_serializer;
    localparam int N = 4, ACCW = 32, OW = 8, SHIFTW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*ACCW-1:0] acc_in = '0;
    logic              capture = 1'b0;
    logic [SHIFTW-1:0] shift = '0;
    logic              clr_acc, busy, overrun, out_valid, out_last;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     out_data;
    logic [1:0]        out_idx;

    int total = 0, bad = 0, clr_cnt = 0;
    logic [7:0] exp_d [4];
    bit         rdy_pat [7];

    acc_drain_serializer #(.N(N), .ACCW(ACCW), .OW(OW), .SHIFTW(SHIFTW)) dut (
        .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .capture(capture), .shift(shift),
        .clr_acc(clr_acc), .busy(busy), .overrun(overrun), .out_data(out_data),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (clr_acc) clr_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [N*ACCW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".busy"},  busy, 0);
        chk({tag, ".last"},  out_last, 0);
        chk({tag, ".idx"},   out_idx, 0);
        chk({tag, ".data"},  out_data, 0);
        chk({tag, ".clr"},   clr_acc, 0);
    endtask

    // Issue one capture pulse from a negedge; returns on the negedge after the capture edge.
    task automatic do_capture(input logic [N*ACCW-1:0] a, input logic [SHIFTW-1:0] s);
        clr_cnt = 0;
        acc_in  = a;
        shift   = s;
        capture = 1'b1;
        @(posedge clk);
        @(negedge clk);
        capture = 1'b0;
        acc_in  = '0;
        chk("cap.clr_acc", clr_acc, 1);
        chk("cap.valid",   out_valid, 1);
    endtask

    // Drain nb beats; use_pat applies rdy_pat, ovr injects a second capture in the first drain cycle.
    task automatic drain(input string tag, input int nb, input bit use_pat, input bit ovr);
        int beat = 0;
        int cyc  = 0;
        while (beat < nb && cyc < 40) begin
            out_ready = use_pat ? rdy_pat[cyc % 7] : 1'b1;
            if (ovr && cyc == 0) begin
                capture = 1'b1;
                acc_in  = pack4(7, 7, 7, 7);
            end else begin
                capture = 1'b0;
            end
            chk({tag, ".valid"}, out_valid, 1);
            chk({tag, ".busy"},  busy, 1);
            chk({tag, ".idx"},   out_idx, beat);
            chk({tag, ".data"},  out_data, exp_d[beat]);
            chk({tag, ".last"},  out_last, beat == 3);
            if (cyc > 0) chk({tag, ".clr_low"}, clr_acc, 0);
            @(posedge clk);
            if (out_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        capture   = 1'b0;
        out_ready = 1'b0;
        chk({tag, ".beats"}, beat, nb);
        if (nb == 4) begin
            chk_idle({tag, ".end"});
            chk({tag, ".clr_once"}, clr_cnt, 1);
        end
    endtask

    initial begin
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
        #2;
        chk_idle("reset");
        chk("reset.overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ACC_DRAIN_SAT_EN
        exp_d = '{8'h19, 8'hFF, 8'h7F, 8'h80};
`else
        exp_d = '{8'h19, 8'hFF, 8'hFA, 8'h06};
`endif
        do_capture(pack4(100, -3, 1000, -1000), 5'd2);
        drain("basic", 4, 1'b0, 1'b0);
        chk("basic.overrun", overrun, 0);

        @(negedge clk);
        do_capture(pack4(100, -3, 1000, -1000), 5'd2);
        drain("bp", 4, 1'b1, 1'b0);

        @(negedge clk);
        do_capture(pack4(100, -3, 1000, -1000), 5'd2);
        drain("ovr", 4, 1'b0, 1'b1);
        chk("ovr.overrun", overrun, 1);

`ifdef ACC_DRAIN_SAT_EN
        exp_d = '{8'h7F, 8'h80, 8'h05, 8'hFB};
`else
        exp_d = '{8'hFF, 8'h00, 8'h05, 8'hFB};
`endif
        @(negedge clk);
        do_capture(pack4(32'h7FFFFFFF, 32'h80000000, 5, -5), 5'd0);
        drain("shift0", 4, 1'b0, 1'b0);

        exp_d = '{8'h02, 8'hFF, 8'h01, 8'h00};
        @(negedge clk);
        do_capture(pack4(3, -3, 1, -1), 5'd1);
        drain("ties", 4, 1'b1, 1'b0);
        chk("ties.overrun_sticky", overrun, 1);

        exp_d = '{8'h19, 8'hFF, 8'h00, 8'h00};
        @(negedge clk);
        do_capture(pack4(100, -3, 1000, -1000), 5'd2);
        drain("pre_rst", 2, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid.overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        exp_d = '{8'h02, 8'hFF, 8'h01, 8'h00};
        do_capture(pack4(3, -3, 1, -1), 5'd1);
        drain("after_rst", 4, 1'b0, 1'b0);
        chk("after_rst.overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
